// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two requesters access to one shared data memory.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t            state;
    logic              gnt;
    logic              last;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              win;
    logic              acc;
    always_comb begin
        win = (req0 && req1) ? !last : req1;
        // rst gates the memory strobes so a reset on the ACC edge cannot write
        acc = (state == ACC) && !rst;
    end
    assign busy            = state != IDLE;
    assign mem_access_addr = acc ? addr_q : '0;
    assign mem_write_data  = acc ? wdata_q : '0;
    assign mem_write_en    = acc && we_q;
    assign mem_read        = acc && !we_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            gnt     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    state   <= ACC;
                    gnt     <= win;
                    last    <= win;
                    we_q    <= win ? we1 : we0;
                    addr_q  <= win ? addr1 : addr0;
                    wdata_q <= win ? wdata1 : wdata0;
                end
                ACC: begin
                    state <= DONE;
                    ack0  <= !gnt;
                    ack1  <= gnt;
                    if (!we_q && !gnt) rdata0 <= mem_read_data;
                    if (!we_q && gnt) rdata1 <= mem_read_data;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a small behavioural memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, mem_write_en, mem_read;
    logic [15:0] rdata0, rdata1, mem_access_addr, mem_write_data, mem_read_data;
    logic [15:0] mem [16];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    // shared memory: preload while ld, synchronous write, combinational read
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[3] <= 16'hA5A5;
        end else if (mem_write_en) begin
            mem[mem_access_addr[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_mem_rd", mem_read, 0);
        chk("rst_mem_addr", mem_access_addr, 0);
        rst = 0;
        ld = 0;
        tick();
        // single read on port 0
        req0 = 1; we0 = 0; addr0 = 3;
        tick();
        chk("rd_busy", busy, 1);
        chk("rd_mem_rd", mem_read, 1);
        chk("rd_mem_we", mem_write_en, 0);
        chk("rd_addr", mem_access_addr, 3);
        chk("rd_ack0_early", ack0, 0);
        tick();
        chk("rd_ack0", ack0, 1);
        chk("rd_ack1", ack1, 0);
        chk("rd_rdata0", rdata0, 16'hA5A5);
        chk("rd_mem_rd_off", mem_read, 0);
        chk("rd_addr_off", mem_access_addr, 0);
        req0 = 0;
        tick();
        chk("rd_ack0_once", ack0, 0);
        chk("rd_idle", busy, 0);
        // single write on port 1
        req1 = 1; we1 = 1; addr1 = 5; wdata1 = 16'h1234;
        tick();
        chk("wr_mem_we", mem_write_en, 1);
        chk("wr_mem_rd", mem_read, 0);
        chk("wr_addr", mem_access_addr, 5);
        chk("wr_data", mem_write_data, 16'h1234);
        tick();
        chk("wr_mem_we_once", mem_write_en, 0);
        chk("wr_ack1", ack1, 1);
        chk("wr_ack0", ack0, 0);
        chk("wr_rdata1_kept", rdata1, 0);
        req1 = 0; we1 = 0;
        tick();
        req0 = 1; addr0 = 5;
        tick();
        tick();
        chk("wr_readback_ack", ack0, 1);
        chk("wr_readback", rdata0, 16'h1234);
        req0 = 0;
        tick();
        // contention from reset release: order 0,1,0,1, one access per 3 cycles
        rst = 1;
        tick();
        req0 = 1; req1 = 1; addr0 = 3; addr1 = 4;
        rst = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("ct_ack0_%0d", k), ack0, (k == 2 || k == 8) ? 1 : 0);
            chk($sformatf("ct_ack1_%0d", k), ack1, (k == 5 || k == 11) ? 1 : 0);
            chk($sformatf("ct_busy_%0d", k), busy, (k % 3 != 0) ? 1 : 0);
            if (k == 2 || k == 8) chk($sformatf("ct_rdata0_%0d", k), rdata0, 16'hA5A5);
            if (k == 5 || k == 11) chk($sformatf("ct_rdata1_%0d", k), rdata1, 16'h1004);
        end
        req0 = 0; req1 = 0;
        tick();
        // withdrawal: req0 dropped during ACC still completes
        req0 = 1; addr0 = 4;
        tick();
        req0 = 0;
        tick();
        chk("wd_ack0", ack0, 1);
        chk("wd_rdata0", rdata0, 16'h1004);
        tick();
        chk("wd_busy0", busy, 0);
        tick();
        chk("wd_no_regrant", busy, 0);
        chk("wd_no_ack", ack0, 0);
        // inputs changed during ACC do not affect the access
        req0 = 1; addr0 = 3;
        tick();
        addr0 = 4; we0 = 1;
        #1;
        chk("ic_addr", mem_access_addr, 3);
        chk("ic_we", mem_write_en, 0);
        tick();
        chk("ic_ack0", ack0, 1);
        chk("ic_rdata0", rdata0, 16'hA5A5);
        req0 = 0; we0 = 0;
        tick();
        // reset during the ACC cycle of a write suppresses it
        req1 = 1; we1 = 1; addr1 = 2; wdata1 = 16'hFFFF;
        tick();
        chk("rw_we_pre", mem_write_en, 1);
        rst = 1;
        #1;
        chk("rw_we_gated", mem_write_en, 0);
        tick();
        chk("rw_busy", busy, 0);
        chk("rw_ack1", ack1, 0);
        rst = 0; req1 = 0; we1 = 0;
        tick();
        chk("rw_ack1_late", ack1, 0);
        req0 = 1; addr0 = 2;
        tick();
        tick();
        chk("rw_readback_ack", ack0, 1);
        chk("rw_mem2", rdata0, 16'h1002);
        req0 = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
